if_id_skid_buffer: RTL and testbench
====================================

IF_ID_SKID_BUFFER -- requirements
Module: if_id_skid_buffer

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 32, giving the program counter width in bits.
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h0000_0000, giving the instruction word driven while no entry is valid.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: the fetch stage offers an entry; input from the instruction word select mux output.
REQ-006 Port in_ready, output, 1 bit: the buffer can accept an entry this cycle.
REQ-007 Port in_inst, input, 32 bits: the selected instruction word.
REQ-008 Port in_pc, input, PC_WIDTH bits: the PC of in_inst.
REQ-009 Port flush, input, 1 bit: discard all held entries (branch taken or exception redirect).
REQ-010 Port out_valid, output, 1 bit: an entry is presented to decode.
REQ-011 Port out_ready, input, 1 bit: decode consumes the entry this cycle.
REQ-012 Port out_inst, output, 32 bits: the instruction word presented to decode.
REQ-013 Port out_pc, output, PC_WIDTH bits: the PC presented to decode.

Function
REQ-014 push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-015 Storage SHALL be two entries: a main register (drives outputs) and a skid register; each holds {inst, pc}.
REQ-016 State machine SHALL have states EMPTY (neither valid), ONE (main valid), and FULL (main and skid valid).
REQ-017 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded combinationally from the state register only, never from out_ready.
REQ-018 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-019 out_inst/out_pc SHALL come from the main register when out_valid=1; otherwise out_inst=NOP_WORD and out_pc=0.
REQ-020 EMPTY transitions: push -> ONE, main<=in; otherwise stay.
REQ-021 ONE transitions: push&pop -> ONE, main<=in; push&~pop -> FULL, skid<=in; ~push&pop -> EMPTY; neither -> stay.
REQ-022 FULL transitions: pop -> ONE, main<=skid; otherwise stay with both registers unchanged.
REQ-023 Latency SHALL be 1 cycle: an entry pushed in cycle N is presented with out_valid=1 in cycle N+1 when the buffer was EMPTY, or ONE with a simultaneous pop.
REQ-024 While out_valid=1 and out_ready=0, out_inst/out_pc SHALL hold stable.
REQ-025 Entries SHALL leave in acceptance order; no entry is duplicated or dropped except by flush.
REQ-026 flush=1 SHALL force the next state to EMPTY regardless of push/pop in the same cycle; a simultaneously offered entry is discarded.
REQ-027 An entry popped in the flush cycle counts as consumed; decode is responsible for squashing it.
REQ-028 The cycle after flush, in_ready SHALL be 1 and out_valid 0.
REQ-029 Register data contents need not be cleared on flush or reset; only the state register is cleared.

Reset
REQ-030 With rst_n=0 at a clock edge, the state SHALL become EMPTY, overriding flush, push and pop.
REQ-031 After reset: out_valid=0, in_ready=1, out_inst=NOP_WORD, out_pc=0.
REQ-032 Reset asserted mid-operation (state ONE or FULL) SHALL discard all entries at that edge.

Verification
REQ-033 Reset then push {inst=32'h1234_5678, pc=0x100} with out_ready=1 -> next cycle out_valid=1, out_inst=32'h1234_5678, out_pc=0x100.
REQ-034 Push A(pc 0x0), B(0x4), C(0x8) on back-to-back cycles with out_ready=0 -> A, B held; in_ready=0 after B; C not accepted; out_inst stays A.
REQ-035 Raise out_ready from the FULL state -> A, B, C (C re-offered) appear in order on consecutive pops; no gaps once FULL drains.
REQ-036 Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_inst=NOP_WORD, in_ready=1; the offered entry never appears.
REQ-037 Streaming with in_valid=1 and out_ready=1 for 16 cycles, pc incrementing by 4 -> 16 contiguous outputs, state stays ONE, throughput 1 per cycle.
REQ-038 rst_n=0 for one cycle while FULL -> next cycle out_valid=0, in_ready=1, then normal pushes resume.

Source files
------------

// File: rtl/if_id_skid_buffer.sv
// Two-entry skid buffer between instruction fetch and decode.
// in_ready depends only on the registered state, so the fetch side never sees a combinational path from decode.
module if_id_skid_buffer #(
  parameter int          PC_WIDTH = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [PC_WIDTH-1:0] out_pc
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [31:0]         main_inst;
  logic [PC_WIDTH-1:0] main_pc;
  logic [31:0]         skid_inst;
  logic [PC_WIDTH-1:0] skid_pc;
  logic                push;
  logic                pop;
  logic                load_main_in;
  logic                load_main_skid;
  logic                load_skid_in;

  assign in_ready  = (state == EMPTY) || (state == ONE);
  assign out_valid = (state == ONE) || (state == FULL);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_inst  = out_valid ? main_inst : NOP_WORD;
  assign out_pc    = out_valid ? main_pc : '0;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          state_next   = FULL;
          load_skid_in = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Redirect wins over everything; data loads are harmless since the state goes EMPTY.
    if (flush) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_inst <= in_inst;
      main_pc   <= in_pc;
    end else if (load_main_skid) begin
      main_inst <= skid_inst;
      main_pc   <= skid_pc;
    end
    if (load_skid_in) begin
      skid_inst <= in_inst;
      skid_pc   <= in_pc;
    end
  end

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed vector bench for if_id_skid_buffer: a table of per-cycle inputs and
// the outputs expected in that same cycle, plus a streaming sequence.
module tb_if_id_skid_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int checks;
  int errors;
  vec_t vecs[24];

  if_id_skid_buffer #(
    .PC_WIDTH(32),
    .NOP_WORD(NOP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .in_pc    (in_pc),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_pc   (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] ii,
                              input logic [31:0] ip, input logic fl, input logic ordy,
                              input logic eir, input logic eov, input logic [31:0] ei,
                              input logic [31:0] ep);
    vec_t v;
    v.rst_n = r; v.in_valid = iv; v.in_inst = ii; v.in_pc = ip;
    v.flush = fl; v.out_ready = ordy;
    v.exp_in_ready = eir; v.exp_out_valid = eov; v.exp_inst = ei; v.exp_pc = ep;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] ii,
                               input logic [31:0] ip, input logic fl, input logic ordy);
    rst_n     = r;
    in_valid  = iv;
    in_inst   = ii;
    in_pc     = ip;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic eir, input logic eov,
                          input logic [31:0] ei, input logic [31:0] ep);
    checkOutput({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, eir});
    checkOutput({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, eov});
    checkOutput({tag, " out_inst"}, out_inst, ei);
    checkOutput({tag, " out_pc"}, out_pc, ep);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //          rst iv inst           pc      fl ordy | ir ov inst           pc
    vecs[0]  = mk(1, 1, 32'h1234_5678, 32'h100, 0, 1,   1, 0, NOP,           32'h0);
    vecs[1]  = mk(1, 0, 32'h0,         32'h0,   0, 1,   1, 1, 32'h1234_5678, 32'h100);
    vecs[2]  = mk(1, 1, 32'hAAAA_0000, 32'h0,   0, 0,   1, 0, NOP,           32'h0);
    vecs[3]  = mk(1, 1, 32'hBBBB_0004, 32'h4,   0, 0,   1, 1, 32'hAAAA_0000, 32'h0);
    vecs[4]  = mk(1, 1, 32'hCCCC_0008, 32'h8,   0, 0,   0, 1, 32'hAAAA_0000, 32'h0);
    vecs[5]  = mk(1, 1, 32'hCCCC_0008, 32'h8,   0, 0,   0, 1, 32'hAAAA_0000, 32'h0);
    vecs[6]  = mk(1, 1, 32'hCCCC_0008, 32'h8,   0, 1,   0, 1, 32'hAAAA_0000, 32'h0);
    vecs[7]  = mk(1, 1, 32'hCCCC_0008, 32'h8,   0, 1,   1, 1, 32'hBBBB_0004, 32'h4);
    vecs[8]  = mk(1, 0, 32'h0,         32'h0,   0, 1,   1, 1, 32'hCCCC_0008, 32'h8);
    vecs[9]  = mk(1, 0, 32'h0,         32'h0,   0, 1,   1, 0, NOP,           32'h0);
    vecs[10] = mk(1, 1, 32'hDDDD_000C, 32'hC,   0, 0,   1, 0, NOP,           32'h0);
    vecs[11] = mk(1, 1, 32'hEEEE_0010, 32'h10,  0, 0,   1, 1, 32'hDDDD_000C, 32'hC);
    vecs[12] = mk(1, 1, 32'hFFFF_0014, 32'h14,  1, 0,   0, 1, 32'hDDDD_000C, 32'hC);
    vecs[13] = mk(1, 1, 32'hFFFF_0014, 32'h14,  0, 1,   1, 0, NOP,           32'h0);
    vecs[14] = mk(1, 0, 32'h0,         32'h0,   0, 1,   1, 1, 32'hFFFF_0014, 32'h14);
    vecs[15] = mk(1, 1, 32'h1111_0018, 32'h18,  0, 0,   1, 0, NOP,           32'h0);
    vecs[16] = mk(1, 1, 32'h2222_001C, 32'h1C,  1, 1,   1, 1, 32'h1111_0018, 32'h18);
    vecs[17] = mk(1, 0, 32'h0,         32'h0,   0, 1,   1, 0, NOP,           32'h0);
    vecs[18] = mk(1, 1, 32'h3333_0020, 32'h20,  0, 0,   1, 0, NOP,           32'h0);
    vecs[19] = mk(1, 1, 32'h4444_0024, 32'h24,  0, 0,   1, 1, 32'h3333_0020, 32'h20);
    vecs[20] = mk(0, 1, 32'h5555_0028, 32'h28,  0, 1,   0, 1, 32'h3333_0020, 32'h20);
    vecs[21] = mk(1, 1, 32'h6666_002C, 32'h2C,  0, 0,   1, 0, NOP,           32'h0);
    vecs[22] = mk(1, 0, 32'h0,         32'h0,   0, 1,   1, 1, 32'h6666_002C, 32'h2C);
    vecs[23] = mk(1, 0, 32'h0,         32'h0,   0, 1,   1, 0, NOP,           32'h0);

    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
    #1;
    tick();
    applyStimulus(0, 1, 32'h9999_9999, 32'h999, 1, 1);
    tick();

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].in_valid, vecs[i].in_inst,
                    vecs[i].in_pc, vecs[i].flush, vecs[i].out_ready);
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid,
               vecs[i].exp_inst, vecs[i].exp_pc);
      tick();
    end

    // Streaming: one push and one pop every cycle, output lags input by one cycle.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        applyStimulus(1, 1, 32'hA500_0000 | i, 32'h200 + 4 * i, 0, 1);
      end else begin
        applyStimulus(1, 0, 32'h0, 32'h0, 0, 1);
      end
      #1;
      if (i == 0) begin
        checkAll("stream0", 1'b1, 1'b0, NOP, 32'h0);
      end else begin
        checkAll($sformatf("stream%0d", i), 1'b1, 1'b1, 32'hA500_0000 | (i - 1),
                 32'h200 + 4 * (i - 1));
      end
      tick();
    end
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 0);
    #1;
    checkAll("stream_drained", 1'b1, 1'b0, NOP, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
